// File: rtl/hex_display_scan_if.sv
// rtl/hex_display_scan_if.sv - display word, enable and active-low drive signals of the 8-digit scanner
interface hex_display_scan_if;
   logic [31:0] i_hex_disp;
   logic [7:0]  i_dp;
   logic        i_en;
   logic [6:0]  o_seg;
   logic        o_dp;
   logic [7:0]  o_an;

   // Source of the display word; observes the panel drive.
   modport master (
      output i_hex_disp, i_dp, i_en,
      input  o_seg, o_dp, o_an
   );

   // The scanner itself.
   modport slave (
      input  i_hex_disp, i_dp, i_en,
      output o_seg, o_dp, o_an
   );
endinterface

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - time-multiplexed 8-digit common-anode 7-segment scanner (option macro HEX_DISP_LZB_EN)
module hex_display_scan #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   hex_display_scan_if.slave  disp
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       dig_q, dig_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [7:0]       dp_shadow_q, dp_shadow_d;
   logic             load_pend_q, load_pend_d;
   logic [7:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   logic             slot_end;
   logic             frame_load;
   logic [3:0]       cur_nib;
   logic             blank_digit;

   // Hex nibble to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0:    glyph = 7'h40;
         4'h1:    glyph = 7'h79;
         4'h2:    glyph = 7'h24;
         4'h3:    glyph = 7'h30;
         4'h4:    glyph = 7'h19;
         4'h5:    glyph = 7'h12;
         4'h6:    glyph = 7'h02;
         4'h7:    glyph = 7'h78;
         4'h8:    glyph = 7'h00;
         4'h9:    glyph = 7'h10;
         4'hA:    glyph = 7'h08;
         4'hB:    glyph = 7'h03;
         4'hC:    glyph = 7'h46;
         4'hD:    glyph = 7'h21;
         4'hE:    glyph = 7'h06;
         default: glyph = 7'h0E;
      endcase
   endfunction

`ifdef HEX_DISP_LZB_EN
   logic [7:0] lead_zero;

   // A digit is a leading zero when it and every digit above it are 0; digit 0 always shows.
   always_comb begin
      lead_zero    = 8'h00;
      lead_zero[7] = (shadow_q[31:28] == 4'h0);
      for (int k = 6; k >= 1; k--) begin
         lead_zero[k] = lead_zero[k+1] && (shadow_q[4*k +: 4] == 4'h0);
      end
   end

   assign blank_digit = lead_zero[dig_q];
`else
   assign blank_digit = 1'b0;
`endif

   assign cur_nib = shadow_q[{dig_q, 2'b00} +: 4];

   // Prescaler, digit stepping and once-per-frame capture of the display word.
   always_comb begin
      slot_end    = (cnt_q == CNT_LAST);
      cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
      dig_d       = slot_end ? dig_q + 3'd1 : dig_q;
      frame_load  = load_pend_q || (slot_end && (dig_q == 3'd7));
      shadow_d    = frame_load ? disp.i_hex_disp : shadow_q;
      dp_shadow_d = frame_load ? disp.i_dp : dp_shadow_q;
      load_pend_d = 1'b0;
   end

   // Output decode from current state; the anode is gated by enable and the blank window.
   always_comb begin
      an_d = 8'hFF;
      if (disp.i_en && (cnt_q >= CNT_BLANK)) begin
         an_d[dig_q] = 1'b0;
      end
      seg_d = blank_digit ? 7'h7F : glyph(cur_nib);
      dp_d  = ~dp_shadow_q[dig_q];
   end

   // State and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q       <= '0;
         dig_q       <= 3'd0;
         shadow_q    <= 32'h0;
         dp_shadow_q <= 8'h00;
         load_pend_q <= 1'b1;
         an_q        <= 8'hFF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         dig_q       <= dig_d;
         shadow_q    <= shadow_d;
         dp_shadow_q <= dp_shadow_d;
         load_pend_q <= load_pend_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign disp.o_an  = an_q;
   assign disp.o_seg = seg_q;
   assign disp.o_dp  = dp_q;

endmodule
